// File: rtl/radix_bin2tern_tx.sv
// Serial binary-to-ternary transmitter: converts a WIDTH-bit word to NTRITS trits, sent MS trit first.
// Optional RADIX_LZ_SUPPRESS_EN skips leading zero trits (at least one trit is always sent).
module radix_bin2tern_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NTRITS = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [1:0]       trit_out_o,
  output logic             trit_valid_o,
  output logic             trit_last_o,
  input  logic             trit_ready_i
);

  localparam int unsigned CntW = (NTRITS > 1) ? $clog2(NTRITS) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NTRITS - 1);

  typedef enum logic [1:0] {StIdle, StConv, StSend} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CntW-1:0]         ptr_q, ptr_d;
  logic [2*NTRITS-1:0]     trit_buf_q, trit_buf_d;
  logic [1:0]              trit_out_q, trit_out_d;
  logic                    trit_valid_q, trit_valid_d;
  logic                    trit_last_q, trit_last_d;

  logic [WIDTH-1:0]        quot;
  logic [WIDTH-1:0]        resid_full;
  logic [1:0]              resid;
  logic [CntW-1:0]         start_ptr;
  logic [CntW-1:0]         ptr_dec;

  function automatic logic [1:0] enc_trit(input logic [1:0] t);
    case (t)
      2'd1:    enc_trit = 2'b11;
      2'd2:    enc_trit = 2'b10;
      default: enc_trit = 2'b01;
    endcase
  endfunction

  assign quot       = rem_q / WIDTH'(3);
  assign resid_full = rem_q - quot * WIDTH'(3);
  assign resid      = resid_full[1:0];
  assign ptr_dec    = ptr_q - 1'b1;

  // First trit to present; with suppression, the highest nonzero trit (or trit 0).
  always_comb begin
    start_ptr = LastIdx;
`ifdef RADIX_LZ_SUPPRESS_EN
    start_ptr = '0;
    for (int unsigned i = 0; i < NTRITS; i++) begin
      if (trit_buf_q[2*i +: 2] != 2'd0) start_ptr = CntW'(i);
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    trit_buf_d   = trit_buf_q;
    trit_out_d   = trit_out_q;
    trit_valid_d = trit_valid_q;
    trit_last_d  = trit_last_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          rem_d   = in_data_i;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        rem_d                   = quot;
        trit_buf_d[2*cnt_q +: 2] = resid;
        cnt_d                   = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StSend;
      end
      StSend: begin
        if (!trit_valid_q) begin
          // Output-register load cycle after conversion.
          ptr_d        = start_ptr;
          trit_out_d   = enc_trit(trit_buf_q[2*start_ptr +: 2]);
          trit_last_d  = (start_ptr == '0);
          trit_valid_d = 1'b1;
        end else if (trit_ready_i) begin
          if (trit_last_q) begin
            trit_valid_d = 1'b0;
            trit_out_d   = 2'b01;
            trit_last_d  = 1'b0;
            state_d      = StIdle;
          end else begin
            ptr_d       = ptr_dec;
            trit_out_d  = enc_trit(trit_buf_q[2*ptr_dec +: 2]);
            trit_last_d = (ptr_dec == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      trit_buf_q   <= '0;
      trit_out_q   <= 2'b01;
      trit_valid_q <= 1'b0;
      trit_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      trit_buf_q   <= trit_buf_d;
      trit_out_q   <= trit_out_d;
      trit_valid_q <= trit_valid_d;
      trit_last_q  <= trit_last_d;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign trit_out_o   = trit_out_q;
  assign trit_valid_o = trit_valid_q;
  assign trit_last_o  = trit_last_q;

endmodule

// File: tb/tb_radix_bin2tern_tx.sv
// Scoreboard bench for radix_bin2tern_tx: expected trits are queued at word acceptance
// and compared as each trit transfers.
module tb_radix_bin2tern_tx;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NTRITS = 6;
`ifdef RADIX_LZ_SUPPRESS_EN
  localparam int BpSkip = 0;
`else
  localparam int BpSkip = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       trit_out;
  logic             trit_valid;
  logic             trit_last;
  logic             trit_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_q[$];
  int   cyc = 0, acc_cyc = 0, last_xfer_cyc = 0, xfer_cnt = 0, n_acc = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;
  logic [1:0] prev_out = 2'b01;
  bit   b2b_arm = 1'b0;

  always #5 clk = ~clk;

  radix_bin2tern_tx #(.WIDTH(WIDTH), .NTRITS(NTRITS)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .trit_out_o   (trit_out),
    .trit_valid_o (trit_valid),
    .trit_last_o  (trit_last),
    .trit_ready_i (trit_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input int d);
    return (d == 0) ? 2'b01 : (d == 1) ? 2'b11 : 2'b10;
  endfunction

  function automatic void push_word(input logic [WIDTH-1:0] w);
    int dig[NTRITS];
    int v = int'(w);
    int top = NTRITS - 1;
    for (int i = 0; i < NTRITS; i++) begin
      dig[i] = v % 3;
      v = v / 3;
    end
`ifdef RADIX_LZ_SUPPRESS_EN
    while (top > 0 && dig[top] == 0) top--;
`endif
    for (int i = top; i >= 0; i--) exp_q.push_back({enc(dig[i]), i == 0});
  endfunction

  // Negedge monitor: a handshake seen here completes at the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (trit_valid && !prev_v) check("latency", cyc - acc_cyc, NTRITS + 2);
      if (prev_v && !prev_r) begin
        check("stall_valid", {31'd0, trit_valid}, 1);
        check("stall_data", {29'd0, trit_out, trit_last}, {29'd0, prev_out, prev_last});
      end
      if (!trit_valid) check("idle_out", {29'd0, trit_out, trit_last}, 32'b010);
      if (in_valid && in_ready) begin
        if (b2b_arm) begin
          check("b2b_gap", cyc - last_xfer_cyc, 1);
          b2b_arm = 1'b0;
        end
        acc_cyc = cyc;
        n_acc++;
        push_word(in_data);
      end
      if (trit_valid && trit_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) check("extra_trit", 1, 0);
        else check("trit", {29'd0, trit_out, trit_last}, {29'd0, exp_q.pop_front()});
      end
    end
    prev_v    = trit_valid;
    prev_r    = trit_ready;
    prev_out  = trit_out;
    prev_last = trit_last;
  end

  task automatic wait_accept();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    @(posedge clk); #1;
    in_data  = w;
    in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && in_ready && !trit_valid) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_xfers(input int n);
    int base = xfer_cnt;
    for (int i = 0; i < 200; i++) begin
      if (xfer_cnt >= base + n) return;
      @(negedge clk); #1;
    end
    check("xfer_timeout", 0, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    check({tag, "_valid"}, {31'd0, trit_valid}, 0);
    check({tag, "_out"}, {30'd0, trit_out}, 32'b01);
    check({tag, "_last"}, {31'd0, trit_last}, 0);
  endtask

  initial begin
    int acc_base;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n      = 1'b1;
    trit_ready = 1'b1;

    send_word(8'd5);   wait_done();
    send_word(8'd255); wait_done();
    send_word(8'd0);   wait_done();

    // Backpressure on the 5th trit of 5 (2'b11) with a stray in_valid pulse.
    send_word(8'd5);
    wait_xfers(BpSkip);
    acc_base = n_acc;
    @(posedge clk); #1;
    trit_ready = 1'b0;
    in_data    = 8'd9;
    in_valid   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_busy", {31'd0, in_ready}, 0);
      check("bp_trit", {30'd0, trit_out}, 32'b11);
    end
    @(posedge clk); #1;
    trit_ready = 1'b1;
    in_valid   = 1'b0;
    wait_done();
    check("bp_noaccept", n_acc, acc_base);

    // Reset in the middle of sending 255.
    send_word(8'd255);
    wait_xfers(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midrst");
    exp_q.delete();
    rst_n = 1'b1;
    send_word(8'd5);
    wait_done();

    // Back-to-back words with in_valid held high.
    @(posedge clk); #1;
    in_data  = 8'd1;
    in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_data = 8'd2;
    b2b_arm = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    check("b2b_seen", {31'd0, b2b_arm}, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/radix_bin2tern_tx.md
# radix_bin2tern_tx

Serial binary-to-ternary transmitter: accepts a WIDTH-bit unsigned binary word over a valid/ready handshake, converts it to NTRITS base-3 digits by iterative division by 3, and emits the digits most-significant-trit first on a two-wire ternary-encoded output. It is the encode side of the mixed-radix link: it drives the two-wire ternary lines that the radix-conversion receive logic decodes back to binary.

## Interface
- WIDTH, 8: binary input word width.
- NTRITS, 6: trits per word; must satisfy 3^NTRITS >= 2^WIDTH (8 bits needs 6 trits, since 3^5 = 243 < 256).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock, synchronous, active-low.
- in_data  in  WIDTH  binary word to convert.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; high only in IDLE.
- trit_out  out  2  encoded trit: 0 = 2'b01, 1 = 2'b11, 2 = 2'b10. 2'b00 is never driven.
- trit_valid  out  1  trit_out holds a valid trit.
- trit_last  out  1  qualifies the final trit of the current word.
- trit_ready  in  1  downstream accepts the trit.

## Operation
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_data into the remainder register, clear the trit counter, and go to CONV.
  - CONV: each cycle, remainder <= remainder / 3; store remainder % 3 into trit buffer slot [count], LSB trit first; count++. After NTRITS cycles, go to SEND.
  - SEND: present trit buffer[ptr], with ptr starting at the most-significant trit. On trit_valid & trit_ready, decrement ptr. A transfer with trit_last set returns to IDLE.
- Division uses an exact WIDTH-bit combinational divide-by-3 of the remainder; the quotient never exceeds WIDTH bits. After CONV, the remainder is always 0.
- in_valid outside IDLE is ignored. The word is not latched and is not lost upstream, because in_ready is low.
- trit_out, trit_valid and trit_last are registered. While trit_valid = 0, trit_out = 2'b01 and trit_last = 0.
- trit_out and trit_last hold stable while trit_valid & !trit_ready (AXI-style: no withdrawal of valid).

## Timing
- Reset values (first edge with rst_n = 0): state = IDLE, in_ready = 1, trit_valid = 0, trit_last = 0, trit_out = 2'b01; trit buffer, counters and remainder cleared.
- Reset mid-CONV or mid-SEND aborts the word. No further trits are emitted; in_ready = 1 on the cycle after the reset edge.
- Acceptance edge E0 → trit_valid = 1 from edge E0 + NTRITS + 1 (NTRITS conversion cycles, one cycle to load the output register).
- With trit_ready held high, one trit transfers per cycle, so a word occupies the link for NTRITS consecutive cycles.
- The last transfer happens at edge Ek. Then trit_valid = 0 and in_ready = 1 after Ek. The next word can be accepted at Ek + 1, giving minimum word spacing NTRITS*2 + 2 cycles.
- If trit_ready is low while trit_valid is high, the block stalls indefinitely with no timeout.

## Configuration
- RADIX_LZ_SUPPRESS_EN
  - Defined: in SEND, leading zero trits (most-significant side) are skipped without being presented. At least one trit is always sent, so word 0 emits a single 2'b01 with trit_last = 1. Skipping happens during the output-register load cycle, so first-trit latency is unchanged.
  - Undefined: exactly NTRITS trits are always emitted, including leading zeros.

## Test plan
- Reset, then in_data = 8'd5 with trit_ready = 1. Response: trits 0,0,0,0,1,2 → trit_out 01,01,01,01,11,10. trit_last only on the 6th trit. First trit_valid 7 edges after acceptance.
- in_data = 8'd255 (ternary 100110). Response: 11,01,01,11,11,01. With RADIX_LZ_SUPPRESS_EN defined, the output is identical (no leading zeros).
- in_data = 0. Response: six 2'b01 trits, last flagged. With RADIX_LZ_SUPPRESS_EN defined: one 2'b01 trit with trit_last = 1.
- Backpressure on 8'd5: hold trit_ready = 0 for 3 cycles on the 5th trit. Response: trit_out = 2'b11 and trit_valid stay stable; 2'b10 follows after trit_ready rises. in_valid pulsed meanwhile is not accepted (in_ready = 0).
- Reset mid-SEND: assert rst_n = 0 after the 2nd trit of 8'd255. Response: next cycle trit_valid = 0, trit_out = 2'b01, in_ready = 1. A subsequent 8'd5 converts correctly.
- Back-to-back: in_valid held high with 8'd1 then 8'd2. Response: second acceptance exactly 1 cycle after the first word's last transfer. Streams: 01×5,11 then 01×5,10.
